// File: rtl/uart_send.sv
// rtl/uart_send.sv - UART transmitter with a one-word holding buffer
//
// Serialises DATA_WIDTH-bit words onto uart_tx as: start bit (0), data LSB
// first, then STOP_BITS stop bits (1). A holding buffer accepts the next word
// while the current frame is on the line, so back-to-back frames have no gap.
//
// Parameters:
//   SYS_CLK_FREQ  clock frequency in Hz
//   BPS           baud rate
//   DATA_WIDTH    data bits per frame, 5..9
//   STOP_BITS     1 or 2 (other values unsupported)
//   CNT_CLK_MAX   last value of the per-bit cycle counter, 1..65535
//
// Ports:
//   sys_clk        in   clock
//   rst            in   synchronous active-high reset
//   uart_tx_valid  in   a word is offered on uart_tx_data
//   uart_tx_data   in   word to send
//   uart_tx_ready  out  holding buffer empty, a word can be accepted
//   uart_tx        out  registered serial line, idles high
//   uart_tx_busy   out  frame on the line or buffer occupied

`ifndef SYS_CLK_FREQ
`define SYS_CLK_FREQ 50_000_000
`endif
`ifndef UART_BPS
`define UART_BPS 115_200
`endif
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

module uart_send #(
  parameter int SYS_CLK_FREQ = `SYS_CLK_FREQ,
  parameter int BPS          = `UART_BPS,
  parameter int DATA_WIDTH   = `UART_DATA_WIDTH,
  parameter int STOP_BITS    = 1,
  parameter int CNT_CLK_MAX  = SYS_CLK_FREQ / BPS - 1
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  uart_tx_valid,
  input  logic [DATA_WIDTH-1:0] uart_tx_data,
  output logic                  uart_tx_ready,
  output logic                  uart_tx,
  output logic                  uart_tx_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] CNT_MAX   = 16'(CNT_CLK_MAX);
  localparam logic [3:0]  LAST_BIT  = 4'(DATA_WIDTH - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

  state_t                state;
  state_t                next_state;
  logic [15:0]           cnt_clk;
  logic [3:0]            bit_idx;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_full;
  logic                  tx_next;

  logic                  bit_end;
  logic                  last_data;
  logic                  last_stop;
  logic                  frame_end;
  logic                  load;
  logic [15:0]           shift_ext;

  // cnt_clk sits at 0 in IDLE and CNT_MAX >= 1, so bit_end never fires there.
  assign bit_end   = (state != IDLE) && (cnt_clk == CNT_MAX);
  assign last_data = (bit_idx == LAST_BIT);
  assign last_stop = (stop_cnt == LAST_STOP);
  assign frame_end = (state == STOP) && bit_end && last_stop;

  // The shifter takes the buffered word either from IDLE or straight out of
  // the final stop bit, which is what removes the idle gap between frames.
  assign load = buf_full && ((state == IDLE) || frame_end);

  // Zero-extended copy so the 4-bit bit_idx indexes it without width games.
  assign shift_ext = {{(16 - DATA_WIDTH){1'b0}}, shift};

  assign uart_tx_ready = ~buf_full;
  assign uart_tx_busy  = (state != IDLE) | buf_full;

  // State register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (buf_full) begin
          next_state = START;
        end
      end
      START: begin
        if (bit_end) begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (bit_end && last_data) begin
          next_state = STOP;
        end
      end
      STOP: begin
        if (frame_end) begin
          next_state = buf_full ? START : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Line level for the bit currently being timed; registered into uart_tx so
  // the line lags the state by one cycle uniformly across every bit.
  always_comb begin
    tx_next = 1'b1;
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_ext[bit_idx];
      default: tx_next = 1'b1;
    endcase
  end

  // Datapath: holding buffer, shifter, bit timing and the line register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt_clk  <= 16'd0;
      bit_idx  <= 4'd0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      uart_tx <= tx_next;

      // Capture and drain are exclusive: capture needs an empty buffer,
      // drain needs a full one.
      if (uart_tx_valid && !buf_full) begin
        buf_data <= uart_tx_data;
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end

      if (load) begin
        shift <= buf_data;
      end

      if (state == IDLE || bit_end) begin
        cnt_clk <= 16'd0;
      end else begin
        cnt_clk <= cnt_clk + 16'd1;
      end

      if (bit_end) begin
        case (state)
          START: begin
            bit_idx  <= 4'd0;
            stop_cnt <= 1'b0;
          end
          DATA: begin
            bit_idx <= bit_idx + 4'd1;
          end
          STOP: begin
            stop_cnt <= last_stop ? 1'b0 : stop_cnt + 1'b1;
          end
          default: begin
            bit_idx <= bit_idx;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// tb/tb_uart_send.sv - self-checking bench for uart_send

module tb_uart_send;

  localparam int CYC = 10;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       rst1, v1, rdy1, tx1, busy1;
  logic [7:0] d1;
  logic       rst2, v2, rdy2, tx2, busy2;
  logic [7:0] d2;

  uart_send #(
    .SYS_CLK_FREQ(1_000_000), .BPS(100_000), .DATA_WIDTH(8), .STOP_BITS(1)
  ) dut1 (
    .sys_clk(sys_clk), .rst(rst1), .uart_tx_valid(v1), .uart_tx_data(d1),
    .uart_tx_ready(rdy1), .uart_tx(tx1), .uart_tx_busy(busy1)
  );

  uart_send #(
    .SYS_CLK_FREQ(1_000_000), .BPS(100_000), .DATA_WIDTH(8), .STOP_BITS(2)
  ) dut2 (
    .sys_clk(sys_clk), .rst(rst2), .uart_tx_valid(v2), .uart_tx_data(d2),
    .uart_tx_ready(rdy2), .uart_tx(tx2), .uart_tx_busy(busy2)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] offer_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];

  // Reference schedule: per accepted word, the handshake edge and the edge
  // after which its start bit is on the line.
  int         m_hs[$];
  int         m_fs[$];
  logic [7:0] m_w[$];

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [10:0] frame;   // line bits in time order, bit 0 = start bit
    int          nbits;
  } vec_t;

  vec_t tbl[6];

  // Behavioural receiver on dut1's line: mid-bit sampling, 8N1.
  int         rx_cnt;
  logic       rx_active;
  logic [7:0] rx_word;
  always @(negedge sys_clk) begin
    if (rst1) begin
      rx_active <= 1'b0;
    end else if (!rx_active) begin
      if (tx1 === 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
      end
    end else begin
      if (rx_cnt % CYC == 4 && rx_cnt >= 14 && rx_cnt <= 84) begin
        rx_word[rx_cnt / CYC - 1] <= tx1;
      end
      if (rx_cnt == 94) begin
        rx_active <= 1'b0;
        if (tx1 === 1'b1) rx_q.push_back(rx_word);
      end
      rx_cnt <= rx_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      v1 = v; d1 = d;
    end else begin
      v2 = v; d2 = d;
    end
  endtask

  task automatic get_out(input int sel, output logic tx, output logic rdy, output logic bz);
    if (sel == 0) begin
      tx = tx1; rdy = rdy1; bz = busy1;
    end else begin
      tx = tx2; rdy = rdy2; bz = busy2;
    end
  endtask

  function automatic int frame_len(input int sb);
    return (1 + 8 + sb) * CYC;
  endfunction

  function automatic logic m_ready(input int t);
    foreach (m_hs[i]) if (t >= m_hs[i] && t <= m_fs[i] - 2) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_busy(input int t, input int sb);
    foreach (m_hs[i]) if (t >= m_hs[i] && t <= m_fs[i] + frame_len(sb) - 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_tx(input int t, input int sb);
    int k;
    foreach (m_fs[i]) begin
      if (t >= m_fs[i] && t < m_fs[i] + frame_len(sb)) begin
        k = (t - m_fs[i]) / CYC;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_w[i][k-1];
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  // Offers offer_q to a DUT and checks {tx, ready, busy} every cycle against
  // the schedule model. hold=1 keeps valid high; otherwise valid is random.
  task automatic run_seq(input int sel, input bit hold, input int budget, input string tag);
    int         t;
    int         last_end;
    int         fs;
    int         sb;
    bit         done;
    logic       v;
    logic [7:0] w;
    logic       tx, rdy, bz;
    t = 0; last_end = 0; done = 1'b0;
    sb = (sel == 0) ? 1 : 2;
    m_hs.delete(); m_fs.delete(); m_w.delete();
    while (!done && t < budget) begin
      get_out(sel, tx, rdy, bz);
      check($sformatf("%s t=%0d {tx,ready,busy}", tag, t),
            {29'd0, tx, rdy, bz}, {29'd0, m_tx(t, sb), m_ready(t), m_busy(t, sb)});
      v = (offer_q.size() > 0) && (hold || $urandom_range(0, 2) == 0);
      w = v ? offer_q[0] : 8'($urandom);
      set_in(sel, v, w);
      if (v && m_ready(t)) begin
        fs = (t + 3 > last_end) ? t + 3 : last_end;
        m_hs.push_back(t + 1);
        m_fs.push_back(fs);
        m_w.push_back(w);
        last_end = fs + frame_len(sb);
        void'(offer_q.pop_front());
      end
      @(negedge sys_clk);
      t++;
      if (offer_q.size() == 0 && t > last_end + 3) done = 1'b1;
    end
    set_in(sel, 1'b0, 8'd0);
    if (!done) check({tag, " cycle budget"}, 32'd0, 32'd1);
  endtask

  task automatic check_rx(input string tag);
    check({tag, " rx word count"}, rx_q.size(), sent_q.size());
    foreach (sent_q[i]) begin
      if (i < rx_q.size()) check($sformatf("%s rx word %0d", tag, i), rx_q[i], sent_q[i]);
    end
  endtask

  // Single word from idle, checked against a hand-written frame pattern.
  task automatic send_one_check(input int sel, input logic [7:0] data, input logic [10:0] frame,
                                input int nbits, input string tag);
    int   len;
    int   line_bad, busy_bad, rdy_bad, first_low;
    logic tx, rdy, bz, exp_tx;
    len = nbits * CYC;
    line_bad = 0; busy_bad = 0; rdy_bad = 0; first_low = -1;
    set_in(sel, 1'b1, data);
    @(negedge sys_clk);
    set_in(sel, 1'b0, 8'($urandom));
    for (int o = 0; o < len + 6; o++) begin
      get_out(sel, tx, rdy, bz);
      if (tx === 1'b0 && first_low < 0) first_low = o;
      exp_tx = (o < 2 || o >= len + 2) ? 1'b1 : frame[(o - 2) / CYC];
      if (tx !== exp_tx) line_bad++;
      if (bz !== (o <= len)) busy_bad++;
      if (rdy !== (o >= 1)) rdy_bad++;
      @(negedge sys_clk);
    end
    check({tag, " start latency"}, first_low, 2);
    check({tag, " line cycles wrong"}, line_bad, 0);
    check({tag, " busy cycles wrong"}, busy_bad, 0);
    check({tag, " ready cycles wrong"}, rdy_bad, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx_low, busy_high;

    tbl[0] = '{0, 8'hA5, 11'b11101001010, 10};
    tbl[1] = '{0, 8'h00, 11'b11000000000, 10};
    tbl[2] = '{0, 8'hFF, 11'b11111111110, 10};
    tbl[3] = '{0, 8'h01, 11'b11000000010, 10};
    tbl[4] = '{1, 8'h3C, 11'b11001111000, 11};
    tbl[5] = '{1, 8'h81, 11'b11100000010, 11};

    rst1 = 1'b1; rst2 = 1'b1;
    set_in(0, 1'b0, 8'd0);
    set_in(1, 1'b0, 8'd0);

    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check($sformatf("reset cyc%0d tx", i), tx1, 1'b1);
      check($sformatf("reset cyc%0d ready", i), rdy1, 1'b1);
      check($sformatf("reset cyc%0d busy", i), busy1, 1'b0);
      check($sformatf("reset2 cyc%0d {tx,ready,busy}", i), {tx2, rdy2, busy2}, 3'b110);
    end
    rst1 = 1'b0; rst2 = 1'b0;

    foreach (tbl[i]) begin
      send_one_check(tbl[i].sel, tbl[i].data, tbl[i].frame, tbl[i].nbits,
                     $sformatf("vec%0d %h", i, tbl[i].data));
    end

    // Back-to-back with valid held
    rx_q.delete();
    offer_q = '{8'h00, 8'hFF}; sent_q = offer_q;
    run_seq(0, 1'b1, 600, "b2b");
    check_rx("b2b");

    // Backpressure: three words offered continuously
    rx_q.delete();
    offer_q = '{8'($urandom), 8'($urandom), 8'($urandom)}; sent_q = offer_q;
    run_seq(0, 1'b1, 800, "bp");
    check_rx("bp");

    // Loopback pattern
    rx_q.delete();
    offer_q = '{8'h00, 8'h55, 8'hAA, 8'hFF}; sent_q = offer_q;
    run_seq(0, 1'b1, 1000, "loop");
    check_rx("loop");

    // Random words, random valid gaps, both stop-bit settings
    rx_q.delete();
    offer_q.delete();
    for (int i = 0; i < 16; i++) offer_q.push_back(8'($urandom));
    sent_q = offer_q;
    run_seq(0, 1'b0, 6000, "rand1");
    check_rx("rand1");

    offer_q.delete();
    for (int i = 0; i < 10; i++) offer_q.push_back(8'($urandom));
    run_seq(1, 1'b0, 5000, "rand2");

    offer_q = '{8'h3C, 8'hC3};
    run_seq(1, 1'b1, 800, "b2b2");

    // Reset during data bit 3 with a second word buffered
    rx_q.delete();
    set_in(0, 1'b1, 8'h96);
    @(negedge sys_clk);
    set_in(0, 1'b1, 8'h3B);
    @(negedge sys_clk);
    @(negedge sys_clk);
    set_in(0, 1'b0, 8'd0);
    repeat (44) @(negedge sys_clk);
    check("midrst pre tx bit3", tx1, 1'b0);
    check("midrst pre busy", busy1, 1'b1);
    check("midrst pre ready", rdy1, 1'b0);
    rst1 = 1'b1;
    @(negedge sys_clk);
    rst1 = 1'b0;
    check("midrst tx", tx1, 1'b1);
    check("midrst ready", rdy1, 1'b1);
    check("midrst busy", busy1, 1'b0);
    tx_low = 0; busy_high = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx1 !== 1'b1) tx_low++;
      if (busy1 !== 1'b0) busy_high++;
      @(negedge sys_clk);
    end
    check("midrst line stays high", tx_low, 0);
    check("midrst stays idle", busy_high, 0);
    check("midrst no word received", rx_q.size(), 0);
    send_one_check(0, 8'h5A, 11'b11010110100, 10, "post-reset 5A");
    sent_q = '{8'h5A};
    check_rx("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
